// File: rtl/and_gate.sv
// Registered bitwise AND of two vectors, plus an all-ones flag and a
// saturating count of the cycles in which that flag was high.
module and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             y_all,
  output logic [CNT_W-1:0] hi_cnt
);

  logic [WIDTH-1:0] w_and;
  logic             w_cnt_sat;
  logic [WIDTH-1:0] r_y;
  logic             r_y_all;
  logic [CNT_W-1:0] r_cnt;

  assign w_and     = a & b;
  assign w_cnt_sat = &r_cnt;

  // The counter looks at the registered flag, so it trails y_all by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y     <= '0;
      r_y_all <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_y     <= w_and;
      r_y_all <= &w_and;
      if (r_y_all && !w_cnt_sat)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign y      = r_y;
  assign y_all  = r_y_all;
  assign hi_cnt = r_cnt;

endmodule

// File: tb/tb_and_gate.sv
// Scoreboard bench for and_gate: a 1-bit instance, a 1-bit instance with a
// 2-bit counter, and an 8-bit instance, all sharing clock and reset.
module tb_and_gate;

  typedef struct packed {
    logic       y1;
    logic       yall1;
    logic [15:0] cnt1;
    logic [1:0] cnt2;
    logic [7:0] y8;
    logic       yall8;
    logic [15:0] cnt8;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a1, b1;
  logic [7:0]  a8, b8;
  logic        y1, yall1, y2, yall2, yall8;
  logic [15:0] cnt1, cnt8;
  logic [1:0]  cnt2;
  logic [7:0]  y8;

  exp_t m;
  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  and_gate #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .y(y1), .y_all(yall1), .hi_cnt(cnt1));
  and_gate #(.WIDTH(1), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .y(y2), .y_all(yall2), .hi_cnt(cnt2));
  and_gate #(.WIDTH(8), .CNT_W(16)) u8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .y(y8), .y_all(yall8), .hi_cnt(cnt8));

  // Reference model: computes what the next edge should produce and queues it.
  task automatic push_exp();
    exp_t e;
    e.y1    = rst ? 1'b0 : (a1 & b1);
    e.yall1 = e.y1;
    e.cnt1  = rst ? 16'd0 : (m.yall1 && m.cnt1 != 16'hFFFF) ? m.cnt1 + 16'd1 : m.cnt1;
    e.cnt2  = rst ? 2'd0  : (m.yall1 && m.cnt2 != 2'd3) ? m.cnt2 + 2'd1 : m.cnt2;
    e.y8    = rst ? 8'h00 : (a8 & b8);
    e.yall8 = rst ? 1'b0 : (e.y8 == 8'hFF);
    e.cnt8  = rst ? 16'd0 : (m.yall8 && m.cnt8 != 16'hFFFF) ? m.cnt8 + 16'd1 : m.cnt8;
    m = e;
    q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic ia, input logic ib,
                     input logic [7:0] ia8, input logic [7:0] ib8);
    @(negedge clk);
    rst = r; a1 = ia; b1 = ib; a8 = ia8; b8 = ib8;
    push_exp();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
      e = q.pop_front();
      n_checks++;
      if (y1 !== 1'b0 || yall1 !== 1'b0 || cnt1 !== 16'd0 || cnt2 !== 2'd0 ||
          y8 !== 8'h00 || yall8 !== 1'b0 || cnt8 !== 16'd0 || y1 !== e.y1) begin
        n_err++;
        $display("FAIL reset[%0d]: got y=%b y_all=%b cnt=%0d cnt2=%0d y8=%h cnt8=%0d, expected all zero",
                 i, y1, yall1, cnt1, cnt2, y8, cnt8);
      end
    end
  endtask

  task automatic test_truth_table();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, i[1], i[0], 8'h00, 8'h00);
      e = q.pop_front();
      n_checks++;
      if (y1 !== e.y1 || yall1 !== e.yall1 || y2 !== e.y1) begin
        n_err++;
        $display("FAIL truth a=%b b=%b: got y=%b y_all=%b y2=%b, expected y=%b y_all=%b",
                 i[1], i[0], y1, yall1, y2, e.y1, e.yall1);
      end
    end
    n_checks++;
    if (y1 !== 1'b1 || yall1 !== 1'b1) begin
      n_err++;
      $display("FAIL truth_11: got y=%b y_all=%b, expected 1 1", y1, yall1);
    end
  endtask

  task automatic test_latency();
    exp_t e;
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    e = q.pop_front();
    // Apply 1,1 right after edge N; y must not move until edge N+1.
    rst = 1'b0; a1 = 1'b1; b1 = 1'b1;
    push_exp();
    @(negedge clk);
    n_checks++;
    if (y1 !== 1'b0 || yall1 !== 1'b0) begin
      n_err++;
      $display("FAIL latency_before: got y=%b y_all=%b, expected 0 0", y1, yall1);
    end
    @(posedge clk);
    #1;
    e = q.pop_front();
    n_checks++;
    if (y1 !== e.y1 || y1 !== 1'b1) begin
      n_err++;
      $display("FAIL latency_after: got y=%b, expected %b", y1, e.y1);
    end
  endtask

  task automatic test_counter();
    exp_t e;
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    e = q.pop_front();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
      e = q.pop_front();
      n_checks++;
      if (cnt1 !== e.cnt1) begin
        n_err++;
        $display("FAIL counter_ramp[%0d]: got hi_cnt=%0d, expected %0d", i, cnt1, e.cnt1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      e = q.pop_front();
      n_checks++;
      if (cnt1 !== e.cnt1 || cnt1 !== 16'd5) begin
        n_err++;
        $display("FAIL counter_hold[%0d]: got hi_cnt=%0d, expected 5", i, cnt1);
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    e = q.pop_front();
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
      e = q.pop_front();
      n_checks++;
      if (cnt2 !== e.cnt2 || cnt1 !== e.cnt1) begin
        n_err++;
        $display("FAIL saturate_ramp[%0d]: got cnt2=%0d cnt=%0d, expected %0d %0d",
                 i, cnt2, cnt1, e.cnt2, e.cnt1);
      end
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      e = q.pop_front();
      n_checks++;
      if (cnt2 !== 2'd3 || cnt1 !== 16'd6 || cnt2 !== e.cnt2) begin
        n_err++;
        $display("FAIL saturate_hold[%0d]: got cnt2=%0d cnt=%0d, expected 3 6", i, cnt2, cnt1);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    e = q.pop_front();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
      e = q.pop_front();
    end
    n_checks++;
    if (cnt1 !== 16'd4 || y1 !== 1'b1 || cnt1 !== e.cnt1) begin
      n_err++;
      $display("FAIL mid_reset_pre: got hi_cnt=%0d y=%b, expected 4 1", cnt1, y1);
    end
    cyc(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
    e = q.pop_front();
    n_checks++;
    if (y1 !== 1'b0 || yall1 !== 1'b0 || cnt1 !== 16'd0 || cnt2 !== 2'd0 ||
        y8 !== 8'h00 || cnt1 !== e.cnt1) begin
      n_err++;
      $display("FAIL mid_reset_edge: got y=%b y_all=%b cnt=%0d cnt2=%0d y8=%h, expected zeros",
               y1, yall1, cnt1, cnt2, y8);
    end
    cyc(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    e = q.pop_front();
    n_checks++;
    if (y1 !== 1'b1 || yall1 !== 1'b1 || cnt1 !== 16'd0 || cnt1 !== e.cnt1) begin
      n_err++;
      $display("FAIL mid_reset_resume: got y=%b y_all=%b cnt=%0d, expected 1 1 0", y1, yall1, cnt1);
    end
    cyc(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    e = q.pop_front();
    n_checks++;
    if (cnt1 !== 16'd1 || cnt1 !== e.cnt1) begin
      n_err++;
      $display("FAIL mid_reset_count: got hi_cnt=%0d, expected 1", cnt1);
    end
  endtask

  task automatic test_width8();
    exp_t e;
    cyc(1'b0, 1'b0, 1'b0, 8'hF0, 8'h3C);
    e = q.pop_front();
    n_checks++;
    if (y8 !== 8'h30 || yall8 !== 1'b0 || y8 !== e.y8) begin
      n_err++;
      $display("FAIL width8_mix: got y=%h y_all=%b, expected 30 0", y8, yall8);
    end
    cyc(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF);
    e = q.pop_front();
    n_checks++;
    if (y8 !== 8'hFF || yall8 !== 1'b1 || yall8 !== e.yall8) begin
      n_err++;
      $display("FAIL width8_ones: got y=%h y_all=%b, expected ff 1", y8, yall8);
    end
    cyc(1'b0, 1'b0, 1'b0, 8'hFE, 8'hFF);
    e = q.pop_front();
    n_checks++;
    if (y8 !== e.y8 || yall8 !== 1'b0 || cnt8 !== e.cnt8 || cnt8 !== 16'd1) begin
      n_err++;
      $display("FAIL width8_count: got y=%h y_all=%b cnt=%0d, expected %h 0 1",
               y8, yall8, cnt8, e.y8);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      cyc(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
          8'($urandom), 8'($urandom | 32'h0F));
      e = q.pop_front();
      n_checks++;
      if ({y1, yall1, cnt1, cnt2, y8, yall8, cnt8} !== {e.y1, e.yall1, e.cnt1, e.cnt2, e.y8, e.yall8, e.cnt8}) begin
        n_err++;
        $display("FAIL random[%0d]: got y=%b cnt=%0d cnt2=%0d y8=%h cnt8=%0d, expected y=%b cnt=%0d cnt2=%0d y8=%h cnt8=%0d",
                 i, y1, cnt1, cnt2, y8, cnt8, e.y1, e.cnt1, e.cnt2, e.y8, e.cnt8);
      end
    end
  endtask

  initial begin
    m   = '0;
    rst = 1'b1; a1 = 1'b1; b1 = 1'b1; a8 = 8'h00; b8 = 8'h00;
    test_reset();
    test_truth_table();
    test_latency();
    test_counter();
    test_saturate();
    test_mid_reset();
    test_width8();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
